// File: rtl/cus43_tile_shifter_if.sv
// Tile shifter bus: generator load strobes, ROM data, CPU latch writes and resolved pixel outputs.
// Handshake: HA2/HB2 are single-cycle load strobes; data is presented with the strobe and never stalled.
interface cus43_tile_shifter_if #(
  parameter int PIX_BITS     = 3,
  parameter int COL_BITS     = 6,
  parameter int PIX_PER_LOAD = 4
);
  logic                              HSYNC;
  logic                              HA2;
  logic                              HB2;
  logic [PIX_BITS*PIX_PER_LOAD-1:0]  GD;
  logic [COL_BITS-1:0]               ATTR;
  logic                              LATCH;
  logic [2:0]                        CA;
  logic [7:0]                        CD;
  logic                              FLIP;
  logic [COL_BITS+PIX_BITS-1:0]      PIX_OUT;
  logic [2:0]                        PRI_OUT;
  logic                              OPAQUE;
  logic                              OVERRUN;
  // Per-layer FSM state, bit 0 = layer A, bit 1 = layer B; 1 = SHIFTING.
  logic [1:0]                        dbg_state;

  modport master (
    output HSYNC, HA2, HB2, GD, ATTR, LATCH, CA, CD, FLIP,
    input  PIX_OUT, PRI_OUT, OPAQUE, OVERRUN, dbg_state
  );

  modport slave (
    input  HSYNC, HA2, HB2, GD, ATTR, LATCH, CA, CD, FLIP,
    output PIX_OUT, PRI_OUT, OPAQUE, OVERRUN, dbg_state
  );
endinterface

// File: rtl/cus43_tile_shifter.sv
// Two-layer tile pixel shifter with hold buffers and priority resolve.
// Optional macro CUS43_FLIP_EN: FLIP=1 reverses pixel order within each load.
module cus43_tile_shifter #(
  parameter int PIX_BITS     = 3,
  parameter int COL_BITS     = 6,
  parameter int PIX_PER_LOAD = 4,
  parameter int TRANSPARENT  = 7
) (
  input  logic               CLK_6M,
  input  logic               RST,
  cus43_tile_shifter_if.slave bus
);
  localparam int GD_W   = PIX_BITS * PIX_PER_LOAD;
  localparam int HOLD_W = GD_W + COL_BITS;
  localparam int IDX_W  = $clog2(PIX_PER_LOAD);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(PIX_PER_LOAD - 1);
  localparam logic [PIX_BITS-1:0] PIX_TR   = PIX_BITS'(TRANSPARENT);

  typedef enum logic {EMPTY = 1'b0, SHIFTING = 1'b1} state_e;

  state_e              state_q   [2];
  state_e              state_d   [2];
  logic [HOLD_W-1:0]   hold_q    [2];
  logic [HOLD_W-1:0]   hold_d    [2];
  logic                hold_vld_q[2];
  logic                hold_vld_d[2];
  logic [HOLD_W-1:0]   shift_q   [2];
  logic [HOLD_W-1:0]   shift_d   [2];
  logic [IDX_W-1:0]    idx_q     [2];
  logic [IDX_W-1:0]    idx_d     [2];
  logic                flip_q    [2];
  logic                flip_d    [2];
  logic [2:0]          pri_q     [2];
  logic [2:0]          pri_d     [2];
  logic                load      [2];
  logic [IDX_W-1:0]    sel       [2];
  logic [PIX_BITS-1:0] lay_pix   [2];
  logic [COL_BITS-1:0] lay_col   [2];

  logic                         hsync_q;
  logic                         overrun_q, overrun_d;
  logic [COL_BITS+PIX_BITS-1:0] pix_q, pix_d;
  logic [2:0]                   pri_out_q, pri_out_d;
  logic                         opaque_q, opaque_d;

  logic [1:0]        strobe;
  logic [HOLD_W-1:0] incoming;
  logic              hsync_rise;

  assign strobe     = {bus.HB2, bus.HA2};
  assign incoming   = {bus.GD, bus.ATTR};
  assign hsync_rise = bus.HSYNC & ~hsync_q;

`ifndef CUS43_FLIP_EN
  logic unused_flip;
  assign unused_flip = bus.FLIP;
`endif

  always_comb begin
    overrun_d = overrun_q;
    for (int l = 0; l < 2; l++) begin
      state_d[l]    = state_q[l];
      hold_d[l]     = hold_q[l];
      hold_vld_d[l] = hold_vld_q[l];
      shift_d[l]    = shift_q[l];
      idx_d[l]      = idx_q[l];
      flip_d[l]     = flip_q[l];
      pri_d[l]      = pri_q[l];
      load[l]       = 1'b0;

      if (bus.LATCH && bus.CA[1:0] == 2'b01 && bus.CA[2] == 1'(l))
        pri_d[l] = bus.CD[3:1];

      if (hsync_rise) begin
        // Line flush: held data is discarded on purpose, so it is not an overrun.
        state_d[l]    = EMPTY;
        idx_d[l]      = '0;
        hold_vld_d[l] = strobe[l];
        if (strobe[l]) hold_d[l] = incoming;
      end else begin
        case (state_q[l])
          EMPTY:    load[l] = hold_vld_q[l];
          SHIFTING: begin
            if (idx_q[l] == IDX_LAST) begin
              load[l] = hold_vld_q[l] | strobe[l];
              if (!load[l]) begin
                state_d[l] = EMPTY;
                idx_d[l]   = '0;
              end
            end else begin
              idx_d[l] = idx_q[l] + 1'b1;
            end
          end
          default:  state_d[l] = EMPTY;
        endcase

        if (load[l]) begin
          // A strobe on the transfer edge bypasses the hold register.
          shift_d[l]    = strobe[l] ? incoming : hold_q[l];
          idx_d[l]      = '0;
          state_d[l]    = SHIFTING;
          hold_vld_d[l] = 1'b0;
`ifdef CUS43_FLIP_EN
          flip_d[l]     = bus.FLIP;
`else
          flip_d[l]     = 1'b0;
`endif
        end else if (strobe[l]) begin
          hold_d[l]     = incoming;
          hold_vld_d[l] = 1'b1;
          if (hold_vld_q[l]) overrun_d = 1'b1;
        end
      end

      sel[l] = flip_q[l] ? ~idx_q[l] : idx_q[l];
      if (state_q[l] == SHIFTING) begin
        lay_pix[l] = shift_q[l][COL_BITS + int'(sel[l]) * PIX_BITS +: PIX_BITS];
        lay_col[l] = shift_q[l][COL_BITS-1:0];
      end else begin
        lay_pix[l] = PIX_TR;
        lay_col[l] = '0;
      end
    end
  end

  logic op_a, op_b, win_b;

  always_comb begin
    op_a  = lay_pix[0] != PIX_TR;
    op_b  = lay_pix[1] != PIX_TR;
    win_b = 1'b0;
    if (op_a && op_b)  win_b = pri_q[1] > pri_q[0];
    else if (op_b)     win_b = 1'b1;
    pix_d     = win_b ? {lay_col[1], lay_pix[1]} : {lay_col[0], lay_pix[0]};
    pri_out_d = win_b ? pri_q[1] : pri_q[0];
    opaque_d  = op_a | op_b;
  end

  always_ff @(posedge CLK_6M or posedge RST) begin
    if (RST) begin
      hsync_q   <= 1'b0;
      overrun_q <= 1'b0;
      pix_q     <= '0;
      pri_out_q <= '0;
      opaque_q  <= 1'b0;
      for (int l = 0; l < 2; l++) begin
        state_q[l]    <= EMPTY;
        hold_q[l]     <= '0;
        hold_vld_q[l] <= 1'b0;
        shift_q[l]    <= '0;
        idx_q[l]      <= '0;
        flip_q[l]     <= 1'b0;
        pri_q[l]      <= '0;
      end
    end else begin
      hsync_q   <= bus.HSYNC;
      overrun_q <= overrun_d;
      pix_q     <= pix_d;
      pri_out_q <= pri_out_d;
      opaque_q  <= opaque_d;
      for (int l = 0; l < 2; l++) begin
        state_q[l]    <= state_d[l];
        hold_q[l]     <= hold_d[l];
        hold_vld_q[l] <= hold_vld_d[l];
        shift_q[l]    <= shift_d[l];
        idx_q[l]      <= idx_d[l];
        flip_q[l]     <= flip_d[l];
        pri_q[l]      <= pri_d[l];
      end
    end
  end

  assign bus.PIX_OUT   = pix_q;
  assign bus.PRI_OUT   = pri_out_q;
  assign bus.OPAQUE    = opaque_q;
  assign bus.OVERRUN   = overrun_q;
  assign bus.dbg_state = {state_q[1] == SHIFTING, state_q[0] == SHIFTING};
endmodule

// File: tb/tb_cus43_tile_shifter.sv
// Directed bench for cus43_tile_shifter: resolve vector table plus load/overrun/hsync/reset sequences.
module tb_cus43_tile_shifter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  cus43_tile_shifter_if bus ();
  cus43_tile_shifter dut (.CLK_6M(clk), .RST(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] pa;  logic [5:0] ca;
    logic [2:0] pb;  logic [5:0] cb;
    logic [2:0] pri_a; logic [2:0] pri_b;
    logic [8:0] exp_pix; logic [2:0] exp_pri; logic exp_opq;
  } vec_t;

  vec_t tv [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic write_reg(input logic [2:0] ca, input logic [7:0] cd);
    bus.CA = ca; bus.CD = cd; bus.LATCH = 1'b1;
    tick();
    bus.LATCH = 1'b0;
  endtask

  task automatic load(input logic b, input logic [11:0] gd, input logic [5:0] attr);
    bus.GD = gd; bus.ATTR = attr;
    if (b) bus.HB2 = 1'b1; else bus.HA2 = 1'b1;
    tick();
    bus.HA2 = 1'b0; bus.HB2 = 1'b0;
  endtask

  function automatic logic [8:0] px(input logic [11:0] gd, input logic [5:0] attr, input int k);
    return {attr, gd[3*k +: 3]};
  endfunction

  logic [11:0] d3 [3];
  logic [11:0] gd_a, gd_b;
  int k;

  initial begin
    bus.HSYNC = 0; bus.HA2 = 0; bus.HB2 = 0; bus.GD = '0; bus.ATTR = '0;
    bus.LATCH = 0; bus.CA = '0; bus.CD = '0; bus.FLIP = 0;

    tv[0] = '{3'd1, 6'h11, 3'd2, 6'h22, 3'd2, 3'd5, {6'h22, 3'd2}, 3'd5, 1'b1};
    tv[1] = '{3'd1, 6'h11, 3'd2, 6'h22, 3'd2, 3'd2, {6'h11, 3'd1}, 3'd2, 1'b1};
    tv[2] = '{3'd7, 6'h11, 3'd3, 6'h22, 3'd0, 3'd0, {6'h22, 3'd3}, 3'd0, 1'b1};
    tv[3] = '{3'd7, 6'h11, 3'd7, 6'h22, 3'd3, 3'd6, {6'h11, 3'd7}, 3'd3, 1'b0};
    tv[4] = '{3'd4, 6'h05, 3'd7, 6'h22, 3'd1, 3'd6, {6'h05, 3'd4}, 3'd1, 1'b1};
    tv[5] = '{3'd6, 6'h3F, 3'd5, 6'h2A, 3'd6, 3'd1, {6'h3F, 3'd6}, 3'd6, 1'b1};
    tv[6] = '{3'd5, 6'h01, 3'd6, 6'h30, 3'd0, 3'd7, {6'h30, 3'd6}, 3'd7, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix", 32'(bus.PIX_OUT), 32'h0);
    chk("rst_pri", 32'(bus.PRI_OUT), 32'h0);
    chk("rst_opq", 32'(bus.OPAQUE), 32'h0);
    chk("rst_ovr", 32'(bus.OVERRUN), 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_pix", 32'(bus.PIX_OUT), 32'h007);
    chk("idle_state", 32'(bus.dbg_state), 32'h0);

    // Single load on layer A, latency N+2
    load(1'b0, 12'o3210, 6'h15);
    tick();
    chk("lat_state", 32'(bus.dbg_state), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("single_pix", 32'(bus.PIX_OUT), 32'(px(12'o3210, 6'h15, i)));
      chk("single_opq", 32'(bus.OPAQUE), 32'h1);
    end
    tick();
    chk("single_end_opq", 32'(bus.OPAQUE), 32'h0);
    chk("single_end_pix", 32'(bus.PIX_OUT), 32'h007);

    // Back-to-back loads every 4 cycles
    d3[0] = 12'o0123; d3[1] = 12'o4561; d3[2] = 12'o2345;
    for (int i = 0; i < 14; i++) begin
      if (i % 4 == 0 && i < 12) begin
        bus.HA2 = 1'b1; bus.GD = d3[i/4]; bus.ATTR = 6'(6'h08 + i);
      end
      tick();
      bus.HA2 = 1'b0;
      if (i >= 2) begin
        k = i - 2;
        chk("stream_pix", 32'(bus.PIX_OUT), 32'(px(d3[k/4], 6'(6'h08 + 4*(k/4)), k % 4)));
        chk("stream_opq", 32'(bus.OPAQUE), 32'h1);
      end
    end
    tick();
    chk("stream_end_opq", 32'(bus.OPAQUE), 32'h0);
    chk("stream_ovr", 32'(bus.OVERRUN), 32'h0);

    // Priority resolve table
    foreach (tv[v]) begin
      write_reg(3'b001, {4'h0, tv[v].pri_a, 1'b0});
      write_reg(3'b101, {4'h0, tv[v].pri_b, 1'b0});
      write_reg(3'b000, 8'hFF);
      write_reg(3'b110, 8'hFF);
      write_reg(3'b111, 8'hFF);
      gd_a = {4{tv[v].pa}};
      gd_b = {4{tv[v].pb}};
      load(1'b0, gd_a, tv[v].ca);
      load(1'b1, gd_b, tv[v].cb);
      tick();
      for (int c = 0; c < 3; c++) begin
        tick();
        chk($sformatf("vec%0d_pix", v), 32'(bus.PIX_OUT), 32'(tv[v].exp_pix));
        chk($sformatf("vec%0d_pri", v), 32'(bus.PRI_OUT), 32'(tv[v].exp_pri));
        chk($sformatf("vec%0d_opq", v), 32'(bus.OPAQUE), 32'(tv[v].exp_opq));
      end
      tick(); tick();
    end
    chk("tbl_ovr", 32'(bus.OVERRUN), 32'h0);
    write_reg(3'b001, 8'h00);
    write_reg(3'b101, 8'h00);

    // HSYNC flush with a strobe on the same edge
    load(1'b0, 12'o6543, 6'h0C);
    tick(); tick();
    chk("hs_pre", 32'(bus.PIX_OUT), 32'(px(12'o6543, 6'h0C, 0)));
    bus.HSYNC = 1'b1; bus.HA2 = 1'b1; bus.GD = 12'o1234; bus.ATTR = 6'h21;
    tick();
    bus.HA2 = 1'b0;
    chk("hs_edge", 32'(bus.PIX_OUT), 32'(px(12'o6543, 6'h0C, 1)));
    chk("hs_state", 32'(bus.dbg_state), 32'h0);
    tick();
    chk("hs_gap_opq", 32'(bus.OPAQUE), 32'h0);
    tick();
    chk("hs_new_pix", 32'(bus.PIX_OUT), 32'(px(12'o1234, 6'h21, 0)));
    chk("hs_ovr", 32'(bus.OVERRUN), 32'h0);
    bus.HSYNC = 1'b0;
    repeat (5) tick();
    chk("hs_done_opq", 32'(bus.OPAQUE), 32'h0);

    // Overrun: two strobes two cycles apart while shifting
    bus.FLIP = 1'b1;
    load(1'b0, 12'o1111, 6'h01);
    tick();
    bus.HA2 = 1'b1; bus.GD = 12'o5555; bus.ATTR = 6'h3F;
    tick();
    bus.HA2 = 1'b0;
    chk("ovr_p0", 32'(bus.PIX_OUT), 32'(px(12'o1111, 6'h01, 0)));
    tick();
    chk("ovr_before", 32'(bus.OVERRUN), 32'h0);
    bus.HA2 = 1'b1; bus.GD = 12'o3210; bus.ATTR = 6'h2A;
    tick();
    bus.HA2 = 1'b0;
    chk("ovr_set", 32'(bus.OVERRUN), 32'h1);
    tick();
    chk("ovr_p3", 32'(bus.PIX_OUT), 32'(px(12'o1111, 6'h01, 3)));
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef CUS43_FLIP_EN
      chk("ovr_second", 32'(bus.PIX_OUT), 32'(px(12'o3210, 6'h2A, 3 - i)));
`else
      chk("ovr_second", 32'(bus.PIX_OUT), 32'(px(12'o3210, 6'h2A, i)));
`endif
    end
    tick();
    chk("ovr_sticky", 32'(bus.OVERRUN), 32'h1);
    bus.FLIP = 1'b0;

    // Asynchronous reset mid-SHIFTING
    load(1'b0, 12'o2345, 6'h03);
    tick(); tick();
    chk("ar_pre_opq", 32'(bus.OPAQUE), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("ar_pix", 32'(bus.PIX_OUT), 32'h0);
    chk("ar_opq", 32'(bus.OPAQUE), 32'h0);
    chk("ar_ovr", 32'(bus.OVERRUN), 32'h0);
    chk("ar_state", 32'(bus.dbg_state), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ar_idle_opq", 32'(bus.OPAQUE), 32'h0);
      chk("ar_idle_pix", 32'(bus.PIX_OUT), 32'h007);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
